// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
//   state_e   - receiver FSM state encoding
//   OS_MID    - oversample count at which a bit is sampled (mid-bit)
//   DATA_BITS - payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int OS_MID    = 7;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: received-byte valid/ready channel.
//   data       - received byte, LSB first on the wire
//   data_valid - data holds an unconsumed byte
//   data_ready - consumer accepts the byte
// master = receiver side, slave = consumer side.
interface uart_rx_8n1_if;

  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/uart_rx_8n1_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
//   clk, rst - clock, asynchronous active-high reset
//   d_i      - asynchronous input
//   q_o      - synchronised output (second stage)
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver, 16x oversampling, mid-bit sampling.
//   clk, rst   - clock, asynchronous active-high reset
//   rx         - raw serial line, idle high
//   divisor    - clocks per oversample tick (0 treated as 1)
//   bus        - received-byte valid/ready channel (master side)
//   frame_err  - one-cycle pulse: stop bit sampled low
//   overrun    - one-cycle pulse: good byte dropped, previous still pending
//   busy       - receiver is not idle
//
// state   | meaning
// IDLE    | waiting for a falling edge on rx_s
// START   | validating the start bit at mid-bit
// DATA    | sampling 8 data bits, LSB first
// STOP    | sampling the stop bit, delivering or flagging the byte
// BREAK   | line held low after a framing error, wait for idle
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] divisor,
  uart_rx_8n1_if.master    bus,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;

  logic             rx_s;
  logic [DIV_W-1:0] div_eff;
  logic             tick;
  logic             mid;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
  assign tick    = (state_q != ST_IDLE) && (presc_q == div_eff - DIV_W'(1));
  assign mid     = tick && (os_q == OS_W'(OS_MID));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = dv_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (dv_q && bus.data_ready) dv_d = 1'b0;

    if (state_q != ST_IDLE) begin
      presc_d = tick ? '0 : presc_q + DIV_W'(1);
      if (tick) os_d = os_q + OS_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Prescaler and os held at 0 here, so START begins a fresh period.
        presc_d = '0;
        os_d    = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (mid) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid) begin
          if (rx_s) begin
            // A consume in this same cycle frees the slot: the load wins.
            if (!dv_q || bus.data_ready) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign frame_err      = fe_q;
  assign overrun        = ov_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
